// File: rtl/wb_b3_burst_ram.sv
// Wishbone B3 responder RAM: classic cycles plus registered-feedback incrementing
// bursts (linear, wrap4/8/16) at one beat per cycle; out-of-range accesses raise err.
module wb_b3_burst_ram #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 1024,
  parameter int AWW   = $clog2(DEPTH)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int NB = DW / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLASSIC = 2'd1,
    BURST   = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t         state_r, next_state_s;
  logic [AWW-1:0] cnt_r, cnt_next_s;
  logic [AWW-1:0] start_idx_s, beat_adr_s;
  logic           req_s, oor_s, beat_s, ack_next_s, err_next_s;
  logic [DW-1:0]  mem_r [DEPTH];
  logic           unused_s;

  // Next word index of a burst; wrap modes only roll the low index bits.
  function automatic logic [AWW-1:0] advance(input logic [AWW-1:0] c, input logic [1:0] bte);
    logic [AWW-1:0] r;
    case (bte)
      2'b00:   r = c + {{(AWW-1){1'b0}}, 1'b1};
      2'b01:   r = {c[AWW-1:2], c[1:0] + 2'd1};
      2'b10:   r = {c[AWW-1:3], c[2:0] + 3'd1};
      2'b11:   r = {c[AWW-1:4], c[3:0] + 4'd1};
      default: r = c + {{(AWW-1){1'b0}}, 1'b1};
    endcase
    return r;
  endfunction

  assign wb_rty_o = 1'b0;
  assign unused_s = &{1'b0, wb_adr_i[1:0]};

  // Next-state, beat qualification and beat address selection.
  always_comb begin
    req_s        = wb_cyc_i & wb_stb_i;
    oor_s        = (wb_adr_i[AW-1:AWW+2] != '0);
    start_idx_s  = wb_adr_i[AWW+1:2];
    next_state_s = IDLE;
    ack_next_s   = 1'b0;
    err_next_s   = 1'b0;
    beat_s       = 1'b0;
    beat_adr_s   = start_idx_s;
    cnt_next_s   = cnt_r;
    if (!wb_cyc_i) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && oor_s) begin
            next_state_s = ERR;
            err_next_s   = 1'b1;
          end else if (req_s && (wb_cti_i == 3'b010)) begin
            next_state_s = BURST;
            ack_next_s   = 1'b1;
            beat_s       = 1'b1;
            cnt_next_s   = advance(start_idx_s, wb_bte_i);
          end else if (req_s) begin
            next_state_s = CLASSIC;
            ack_next_s   = 1'b1;
            beat_s       = 1'b1;
          end else begin
            next_state_s = IDLE;
          end
        end
        // Later beats use the predicted counter, not the master's address.
        BURST: begin
          if (req_s && (wb_cti_i == 3'b010)) begin
            next_state_s = BURST;
            ack_next_s   = 1'b1;
            beat_s       = 1'b1;
            beat_adr_s   = cnt_r;
            cnt_next_s   = advance(cnt_r, wb_bte_i);
          end else begin
            next_state_s = IDLE;
          end
        end
        CLASSIC: next_state_s = IDLE;
        ERR:     next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Byte-lane writes land on the edge that raises ack for the beat.
  always_ff @(posedge wb_clk_i) begin
    if (beat_s && wb_we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (wb_sel_i[i]) begin
          mem_r[beat_adr_s][8*i +: 8] <= wb_dat_i[8*i +: 8];
        end
      end
    end
  end

  // State, burst counter and registered bus responses.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state_r  <= next_state_s;
      cnt_r    <= cnt_next_s;
      wb_ack_o <= ack_next_s;
      wb_err_o <= err_next_s;
      if (beat_s) begin
        wb_dat_o <= mem_r[beat_adr_s];
      end
    end
  end

endmodule

// File: tb/tb_wb_b3_burst_ram.sv
// Scoreboard bench for wb_b3_burst_ram: stimulus queues expected responses with their
// cycle numbers; a monitor matches every ack/err against them.
module tb_wb_b3_burst_ram;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i = 1'b1;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  wb_b3_burst_ram #(.DW(32), .AW(32), .DEPTH(1024)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i),
    .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    int unsigned cyc;
    bit          is_err;
    bit          chk;
    logic [31:0] dat;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned cyc_cnt = 0;
  int          tests = 0;
  int          fails = 0;
  bit          done = 1'b0;
  string       cur_tag = "none";
  logic [31:0] wbuf [16];
  logic [31:0] ebuf [16];

  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic drive(input logic cyc, input logic stb, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti,
                       input logic [1:0] bte);
    wb_cyc_i = cyc; wb_stb_i = stb; wb_we_i = we; wb_adr_i = adr;
    wb_dat_i = dat; wb_sel_i = sel; wb_cti_i = cti; wb_bte_i = bte;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
  endtask

  task automatic expect_rsp(input int unsigned at, input bit is_err, input bit chk, input logic [31:0] dat);
    exp_t x;
    x.cyc = at; x.is_err = is_err; x.chk = chk; x.dat = dat; x.tag = cur_tag;
    exp_q.push_back(x);
  endtask

  // Classic master: holds the request until it sees the response, then releases.
  task automatic classic(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input bit is_err, input bit chk, input logic [31:0] exp_dat);
    expect_rsp(cyc_cnt + 1, is_err, chk, exp_dat);
    drive(1'b1, 1'b1, we, adr, dat, sel, 3'b000, 2'b00);
    drive(1'b1, 1'b1, we, adr, dat, sel, 3'b000, 2'b00);
    idle(1);
  endtask

  // Registered-feedback burst: n beats of data at 010, then 111 in the final ack cycle.
  task automatic burst(input bit we, input logic [31:0] adr, input logic [1:0] bte, input int n, input bit chk);
    for (int i = 0; i < n; i++) expect_rsp(cyc_cnt + 1 + i, 1'b0, chk, ebuf[i]);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, we, adr, wbuf[i], 4'hF, 3'b010, bte);
    drive(1'b1, 1'b1, we, adr, 32'h0, 4'hF, 3'b111, bte);
    idle(1);
  endtask

  // Monitor: reset values on reset assertion, otherwise match each ack/err in order.
  always @(negedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      #1;
      tests++;
      if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== 32'h0 || wb_rty_o !== 1'b0) begin
        fails++;
        $display("FAIL reset: ack=%b err=%b rty=%b dat=%h, required 0 0 0 00000000",
                 wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
        tests++;
        fails++;
        $display("FAIL %s missing: no response in cycle %0d (now %0d)", exp_q[0].tag, exp_q[0].cyc, cyc_cnt);
        void'(exp_q.pop_front());
      end
      if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected: ack=%b err=%b in cycle %0d, required no response", wb_ack_o, wb_err_o, cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc_cnt || wb_rty_o !== 1'b0 || wb_ack_o !== !e.is_err || wb_err_o !== e.is_err ||
              (e.chk && wb_dat_o !== e.dat)) begin
            fails++;
            $display("FAIL %s: cyc=%0d ack=%b err=%b rty=%b dat=%h, required cyc=%0d ack=%b err=%b rty=0 dat=%h",
                     e.tag, cyc_cnt, wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o,
                     e.cyc, !e.is_err, e.is_err, e.chk ? e.dat : wb_dat_o);
          end
        end
      end
      if (done) begin
        tests++;
        if (exp_q.size() != 0) begin
          fails++;
          $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 32'h0;
    wb_dat_i = 32'h0; wb_sel_i = 4'h0; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
    #2 wb_rst_n_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_n_i = 1'b1;
    idle(2);

    cur_tag = "zero_init";
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'h0; ebuf[i] = 32'h0; end
    burst(1'b1, 32'h0, 2'b00, 16, 1'b0);

    cur_tag = "cl_wr";
    classic(1'b1, 32'h10, 32'hAABBCCDD, 4'b0011, 1'b0, 1'b0, 32'h0);
    cur_tag = "cl_rd";
    classic(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0000CCDD);

    cur_tag = "preload";
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    burst(1'b1, 32'h10, 2'b00, 4, 1'b0);
    cur_tag = "lin_rd";
    ebuf[0] = 32'h1; ebuf[1] = 32'h2; ebuf[2] = 32'h3; ebuf[3] = 32'h4;
    burst(1'b0, 32'h10, 2'b00, 4, 1'b1);

    cur_tag = "w8";
    classic(1'b1, 32'h20, 32'h88888888, 4'hF, 1'b0, 1'b0, 32'h0);
    cur_tag = "wrap4_wr";
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    burst(1'b1, 32'h18, 2'b01, 4, 1'b0);
    cur_tag = "wrap4_chk";
    ebuf[0] = 32'hC; ebuf[1] = 32'hD; ebuf[2] = 32'hA; ebuf[3] = 32'hB; ebuf[4] = 32'h88888888;
    burst(1'b0, 32'h10, 2'b00, 5, 1'b1);

    cur_tag = "hi_wr";
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h108 + 32'(i);
    burst(1'b1, 32'h20, 2'b00, 8, 1'b0);
    cur_tag = "wrap8_rd";
    ebuf[0] = 32'h10D; ebuf[1] = 32'h10E; ebuf[2] = 32'h10F; ebuf[3] = 32'h108;
    ebuf[4] = 32'h109; ebuf[5] = 32'h10A; ebuf[6] = 32'h10B; ebuf[7] = 32'h10C;
    burst(1'b0, 32'h34, 2'b10, 8, 1'b1);

    cur_tag = "w0";
    classic(1'b1, 32'h0, 32'h11115555, 4'b1100, 1'b0, 1'b0, 32'h0);
    cur_tag = "w1";
    classic(1'b1, 32'h4, 32'h22222222, 4'hF, 1'b0, 1'b0, 32'h0);
    cur_tag = "wrap16_rd";
    ebuf[0] = 32'h10E; ebuf[1] = 32'h10F; ebuf[2] = 32'h11110000; ebuf[3] = 32'h22222222;
    burst(1'b0, 32'h38, 2'b11, 4, 1'b1);

    cur_tag = "top_wr";
    wbuf[0] = 32'h00000FFE; wbuf[1] = 32'h00000FFF;
    burst(1'b1, 32'hFF8, 2'b00, 2, 1'b0);
    cur_tag = "top_rd";
    ebuf[0] = 32'h00000FFE; ebuf[1] = 32'h00000FFF; ebuf[2] = 32'h11110000; ebuf[3] = 32'h22222222;
    burst(1'b0, 32'hFF8, 2'b00, 4, 1'b1);

    cur_tag = "oor_rd";
    classic(1'b0, 32'h1000, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0);
    cur_tag = "oor_wr";
    classic(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0);
    cur_tag = "oor_chk";
    classic(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h11110000);

    cur_tag = "abort";
    expect_rsp(cyc_cnt + 1, 1'b0, 1'b1, 32'hC);
    expect_rsp(cyc_cnt + 2, 1'b0, 1'b1, 32'hD);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b010, 2'b00);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b010, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b010, 2'b00);
    idle(1);
    cur_tag = "after_abort";
    classic(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h11110000);

    cur_tag = "rst_mid";
    expect_rsp(cyc_cnt + 1, 1'b0, 1'b1, 32'hC);
    expect_rsp(cyc_cnt + 2, 1'b0, 1'b1, 32'hD);
    expect_rsp(cyc_cnt + 3, 1'b0, 1'b1, 32'hA);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b010, 2'b00);
    #5;
    wb_rst_n_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b000;
    @(posedge wb_clk_i);
    #1 wb_rst_n_i = 1'b1;
    idle(3);
    done = 1'b1;
  end

endmodule
